// File: rtl/entry_ctrl_if.sv
// ---------------------------------------------------------------------------
// entry_ctrl_if
//   Bundles the keypad input side and the register-file / ALU control side of
//   entry_ctrl into one interface.
//
//   Keypad side (driven by the keypad / bench):
//     key_valid  one-cycle pulse marking key_code valid
//     key_code   0-9 digits, ENTER and CLEAR codes, anything else invalid
//   Control side (driven by entry_ctrl):
//     level      digit select for the register file, 1 = tens, 0 = ones
//     Din        digit value presented to the register file
//     WE         register-file write enable, one-cycle pulse
//     W1         register-file write index, 0 = operand A, 1 = operand B
//     alu_start  one-cycle pulse once both operands are in the register file
//     done       high while the controller sits in DONE
//     key_err    one-cycle pulse for every rejected key
//     phase      0 = entering A, 1 = entering B, 2 = loading/calculating,
//                3 = done
//
//   Modports: master = keypad/bench side, slave = entry_ctrl side.
// ---------------------------------------------------------------------------
interface entry_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       level;
    logic [3:0] Din;
    logic       WE;
    logic       W1;
    logic       alu_start;
    logic       done;
    logic       key_err;
    logic [1:0] phase;

    modport master (
        output key_valid,
        output key_code,
        input  level,
        input  Din,
        input  WE,
        input  W1,
        input  alu_start,
        input  done,
        input  key_err,
        input  phase
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output level,
        output Din,
        output WE,
        output W1,
        output alu_start,
        output done,
        output key_err,
        output phase
    );
endinterface

// File: rtl/entry_ctrl.sv
// ---------------------------------------------------------------------------
// entry_ctrl
//   Keypad entry controller for a two-operand calculator. Up to two decimal
//   digits are buffered per operand; ENTER streams the operand into a
//   register file as a tens digit followed by a ones digit, then pulses WE.
//   After operand B is written, the controller waits one settle cycle,
//   pulses alu_start, and parks in DONE until the next digit or CLEAR.
//
//   Parameters:
//     ENTER_CODE  key code that commits the current operand
//     CLEAR_CODE  key code that discards the buffered digits
//
//   Ports:
//     CLK    single clock, all state changes on its rising edge
//     RST_N  asynchronous active-low reset
//     bus    entry_ctrl_if.slave (keypad inputs, register-file/ALU outputs)
// ---------------------------------------------------------------------------
module entry_ctrl #(
    parameter logic [3:0] ENTER_CODE = 4'hA,
    parameter logic [3:0] CLEAR_CODE = 4'hB
) (
    input  logic         CLK,
    input  logic         RST_N,
    entry_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_ENTRY_A  = 4'd0,
        S_LOAD_A_T = 4'd1,
        S_LOAD_A_O = 4'd2,
        S_WRITE_A  = 4'd3,
        S_ENTRY_B  = 4'd4,
        S_LOAD_B_T = 4'd5,
        S_LOAD_B_O = 4'd6,
        S_WRITE_B  = 4'd7,
        S_SETTLE   = 4'd8,
        S_START    = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q,   cnt_d;      // number of buffered digits (0..2)
    logic [3:0] tens_q,  tens_d;
    logic [3:0] ones_q,  ones_d;
    logic       level_q, level_d;
    logic [3:0] din_q,   din_d;
    logic       w1_q,    w1_d;
    logic       key_err_q, key_err_d;

    // Key classification
    logic is_digit;
    logic is_enter;
    logic is_clear;

    always_comb begin
        is_digit = (bus.key_code <= 4'd9);
        is_enter = (bus.key_code == ENTER_CODE);
        is_clear = (bus.key_code == CLEAR_CODE);
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_ENTRY_A;
            cnt_q     <= 2'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            level_q   <= 1'b0;
            din_q     <= 4'd0;
            w1_q      <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            level_q   <= level_d;
            din_q     <= din_d;
            w1_q      <= w1_d;
            key_err_q <= key_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    //   level/Din/W1 are loaded on the same edge that enters the matching
    //   state, so the registered values line up exactly with state_q.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        level_d   = level_q;
        din_d     = din_q;
        w1_d      = w1_q;
        key_err_d = 1'b0;

        case (state_q)
            S_ENTRY_A, S_ENTRY_B: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        if (cnt_q == 2'd2) begin
                            // Buffer full: reject, keep both digits.
                            key_err_d = 1'b1;
                        end else if (cnt_q == 2'd1) begin
                            tens_d = ones_q;
                            ones_d = bus.key_code;
                            cnt_d  = 2'd2;
                        end else begin
                            ones_d = bus.key_code;
                            cnt_d  = 2'd1;
                        end
                    end else if (is_enter) begin
                        if (cnt_q == 2'd0) begin
                            key_err_d = 1'b1;
                        end else begin
                            state_d = (state_q == S_ENTRY_A) ? S_LOAD_A_T
                                                             : S_LOAD_B_T;
                            // A single-digit operand has an implicit zero tens.
                            level_d = 1'b1;
                            din_d   = (cnt_q == 2'd2) ? tens_q : 4'd0;
                            w1_d    = (state_q == S_ENTRY_B);
                        end
                    end else if (is_clear) begin
                        cnt_d  = 2'd0;
                        tens_d = 4'd0;
                        ones_d = 4'd0;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end

            S_LOAD_A_T, S_LOAD_B_T: begin
                state_d   = (state_q == S_LOAD_A_T) ? S_LOAD_A_O : S_LOAD_B_O;
                level_d   = 1'b0;
                din_d     = ones_q;
                key_err_d = bus.key_valid;
            end

            S_LOAD_A_O, S_LOAD_B_O: begin
                state_d   = (state_q == S_LOAD_A_O) ? S_WRITE_A : S_WRITE_B;
                key_err_d = bus.key_valid;
            end

            S_WRITE_A, S_WRITE_B: begin
                state_d   = (state_q == S_WRITE_A) ? S_ENTRY_B : S_SETTLE;
                // Next operand starts from an empty buffer.
                cnt_d     = 2'd0;
                tens_d    = 4'd0;
                ones_d    = 4'd0;
                key_err_d = bus.key_valid;
            end

            S_SETTLE: begin
                state_d   = S_START;
                key_err_d = bus.key_valid;
            end

            S_START: begin
                state_d   = S_DONE;
                key_err_d = bus.key_valid;
            end

            S_DONE: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        // A digit both starts a new calculation and counts
                        // as the first digit of operand A.
                        state_d = S_ENTRY_A;
                        cnt_d   = 2'd1;
                        tens_d  = 4'd0;
                        ones_d  = bus.key_code;
                    end else if (is_clear) begin
                        state_d = S_ENTRY_A;
                        cnt_d   = 2'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                    end else if (!is_enter) begin
                        key_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_ENTRY_A;
                cnt_d   = 2'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs decoded from the state register. Because state_q resets
    // asynchronously, WE/alu_start/done/phase drop the moment RST_N falls.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.WE        = 1'b0;
        bus.alu_start = 1'b0;
        bus.done      = 1'b0;
        bus.phase     = 2'd2;

        case (state_q)
            S_ENTRY_A: bus.phase = 2'd0;
            S_ENTRY_B: bus.phase = 2'd1;
            S_WRITE_A,
            S_WRITE_B: bus.WE = 1'b1;
            S_START:   bus.alu_start = 1'b1;
            S_DONE: begin
                bus.done  = 1'b1;
                bus.phase = 2'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.level   = level_q;
        bus.Din     = din_q;
        bus.W1      = w1_q;
        bus.key_err = key_err_q;
    end

endmodule

// File: tb/tb_entry_ctrl.sv
module tb_entry_ctrl;

    localparam logic [3:0] ENT = 4'hA;
    localparam logic [3:0] CLR = 4'hB;

    logic clk = 1'b0;
    logic rst_n;

    entry_ctrl_if bus ();

    entry_ctrl #(
        .ENTER_CODE (ENT),
        .CLEAR_CODE (CLR)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the user has typed, not how the FSM encodes it.
    int m_mode = 0;      // 0 entering A, 1 entering B, 3 done
    int m_buf[$];        // buffered digits, oldest first
    int m_we   = 0;      // expected WE pulses so far
    int m_alu  = 0;      // expected alu_start pulses so far
    int we_seen  = 0;
    int alu_seen = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor; WE and alu_start must never coincide.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.WE === 1'b1)        we_seen++;
            if (bus.alu_start === 1'b1) alu_seen++;
            checks++;
            assert (!(bus.WE === 1'b1 && bus.alu_start === 1'b1))
            else begin
                errors++;
                $error("FAIL we_alu_overlap observed=1 expected=0");
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    bus.WE,        0);
        chk({tag, "_alu"},   bus.alu_start, 0);
        chk({tag, "_done"},  bus.done,      0);
        chk({tag, "_kerr"},  bus.key_err,   0);
        chk({tag, "_level"}, bus.level,     0);
        chk({tag, "_din"},   bus.Din,       0);
        chk({tag, "_w1"},    bus.W1,        0);
        chk({tag, "_phase"}, bus.phase,     0);
    endtask

    // Runs after an accepted ENTER; entered just after the LOAD_x_T edge.
    task automatic run_load(input int idx, input int t, input int o,
                            input bit inject, input bit abort);
        chk("ldt_level", bus.level, 1);
        chk("ldt_din",   bus.Din,   t[7:0]);
        chk("ldt_w1",    bus.W1,    idx[7:0]);
        chk("ldt_phase", bus.phase, 2);
        chk("ldt_we",    bus.WE,    0);
        chk("ldt_kerr",  bus.key_err, 0);
        if (inject) begin
            bus.key_valid = 1'b1;
            bus.key_code  = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk("ldo_level", bus.level, 0);
        chk("ldo_din",   bus.Din,   o[7:0]);
        chk("ldo_w1",    bus.W1,    idx[7:0]);
        chk("ldo_we",    bus.WE,    0);
        chk("ldo_kerr",  bus.key_err, {7'd0, inject});
        @(negedge clk);
        chk("wr_we",    bus.WE,    1);
        chk("wr_w1",    bus.W1,    idx[7:0]);
        chk("wr_level", bus.level, 0);
        chk("wr_din",   bus.Din,   o[7:0]);
        chk("wr_alu",   bus.alu_start, 0);
        m_we++;
        if (!abort) begin
            @(negedge clk);
            if (idx == 0) begin
                m_mode = 1;
                chk("postA_phase", bus.phase, 1);
                chk("postA_we",    bus.WE,    0);
            end else begin
                chk("settle_alu", bus.alu_start, 0);
                chk("settle_we",  bus.WE,        0);
                @(negedge clk);
                chk("start_alu",   bus.alu_start, 1);
                chk("start_phase", bus.phase,     2);
                m_alu++;
                @(negedge clk);
                m_mode = 3;
                chk("done_done",  bus.done,      1);
                chk("done_phase", bus.phase,     3);
                chk("done_alu",   bus.alu_start, 0);
                chk("we_count",   8'(we_seen),   8'(m_we));
                chk("alu_count",  8'(alu_seen),  8'(m_alu));
            end
        end
    endtask

    // Applies one key starting at a falling edge; updates the model and checks.
    task automatic key(input logic [3:0] code, input bit inject, input bit abort);
        bit exp_err = 1'b0;
        bit launch  = 1'b0;
        bit is_dig  = (code <= 4'd9);
        int t = 0;
        int o = 0;
        int idx = 0;
        if (!is_dig && code != ENT && code != CLR) begin
            exp_err = 1'b1;
        end else if (m_mode == 3) begin
            if (is_dig) begin
                m_mode = 0;
                m_buf.delete();
                m_buf.push_back(int'(code));
            end else if (code == CLR) begin
                m_mode = 0;
                m_buf.delete();
            end
        end else if (is_dig) begin
            if (m_buf.size() == 2) exp_err = 1'b1;
            else m_buf.push_back(int'(code));
        end else if (code == CLR) begin
            m_buf.delete();
        end else if (m_buf.size() == 0) begin
            exp_err = 1'b1;
        end else begin
            launch = 1'b1;
            idx = m_mode;
            o = m_buf[m_buf.size() - 1];
            t = (m_buf.size() == 2) ? m_buf[0] : 0;
            m_buf.delete();
        end

        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        $display("key %0h mode=%0d err=%0d launch=%0d", code, m_mode, exp_err, launch);
        if (launch) begin
            run_load(idx, t, o, inject, abort);
        end else begin
            chk("key_err", bus.key_err, {7'd0, exp_err});
            chk("phase",   bus.phase,   8'(m_mode));
            chk("done",    bus.done,    {7'd0, (m_mode == 3)});
            chk("we_idle", bus.WE,      0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_phase", bus.phase, 0);

        // 42 / 7 basic calculation
        key(4'd4, 0, 0); key(4'd2, 0, 0); key(ENT, 0, 0);
        key(4'd7, 0, 0); key(ENT, 0, 0);

        // third digit rejected, then A = 12
        key(4'd1, 0, 0); key(4'd2, 0, 0); key(4'd3, 0, 0); key(ENT, 0, 0);
        key(4'd5, 0, 0); key(ENT, 0, 0);

        // ENTER on empty buffer, CLEAR discards digits
        key(CLR, 0, 0); key(ENT, 0, 0);
        key(4'd5, 0, 0); key(CLR, 0, 0); key(4'd8, 0, 0); key(ENT, 0, 0);

        // key during LOAD_B_T is rejected; sequence unaltered
        key(4'd3, 0, 0); key(ENT, 1, 0);

        // ENTER ignored in DONE, invalid code rejected in DONE
        key(ENT, 0, 0); key(4'hE, 0, 0);

        // digit 9 in DONE starts a new calculation
        key(4'd9, 0, 0); key(ENT, 0, 0);

        // reset during WRITE_B
        key(4'd6, 0, 0); key(ENT, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wr");
        m_mode = 0;
        m_buf.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_alu_count", 8'(alu_seen), 8'(m_alu));
        chk("rst_restart_phase", bus.phase, 0);

        // randomized keys against the model
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [3:0] code;
            r = $urandom_range(0, 99);
            if (r < 55)      code = 4'($urandom_range(0, 9));
            else if (r < 75) code = ENT;
            else if (r < 85) code = CLR;
            else             code = 4'($urandom_range(12, 15));
            key(code, ($urandom_range(0, 3) == 0), 0);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        chk("final_we_count",  8'(we_seen),  8'(m_we));
        chk("final_alu_count", 8'(alu_seen), 8'(m_alu));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
